// File: rtl/uc_pipe_if.sv
// Control-word bus between instruction decode (master) and the control-word
// pipeline (slave). It carries the incoming word, the pipe controls and the
// last-stage outputs.
interface uc_pipe_if #(
  parameter int DEPTH  = 3,
  parameter int SELC_W = 6,
  parameter int TYPE_W = 7,
  parameter int CNT_W  = 16
);
  logic [SELC_W-1:0] SelC_in;
  logic [TYPE_W-1:0] Type_in;
  logic              MR_IN;
  logic              MW_IN;
  logic              VALID_IN;
  logic              STALL;
  logic              FLUSH;

  logic [SELC_W-1:0] SelC_out;
  logic [TYPE_W-1:0] Type_out;
  logic              MR_OUT;
  logic              MW_OUT;
  logic              VALID_OUT;
  logic [DEPTH-1:0]  STAGE_VALID;
  logic [CNT_W-1:0]  BUBBLE_CNT;

  modport master (
    output SelC_in, Type_in, MR_IN, MW_IN, VALID_IN, STALL, FLUSH,
    input  SelC_out, Type_out, MR_OUT, MW_OUT, VALID_OUT, STAGE_VALID, BUBBLE_CNT
  );

  modport slave (
    input  SelC_in, Type_in, MR_IN, MW_IN, VALID_IN, STALL, FLUSH,
    output SelC_out, Type_out, MR_OUT, MW_OUT, VALID_OUT, STAGE_VALID, BUBBLE_CNT
  );
endinterface

// File: rtl/uc_pipe.sv
// Control-word pipeline: carries {SelC, Type, MR, MW} through DEPTH stages,
// clocked on the falling edge of CK3. Supports a stall that freezes stages
// 0..STALL_STAGE (inserting a bubble just above them), a full flush, and
// one-shot memory strobes so a word held in the last stage never re-strobes.
module uc_pipe #(
  parameter int DEPTH       = 3,
  parameter int SELC_W      = 6,
  parameter int TYPE_W      = 7,
  parameter int NOP_SELC    = 35,
  parameter int NOP_TYPE    = 0,
  parameter int STALL_STAGE = 0,
  parameter int CNT_W       = 16
) (
  input  logic       CK3,
  input  logic       RST,
  uc_pipe_if.slave   bus
);

  typedef struct packed {
    logic              v;
    logic [SELC_W-1:0] selc;
    logic [TYPE_W-1:0] typ;
    logic              mr;
    logic              mw;
  } word_t;

  localparam int    LAST      = DEPTH - 1;
  // Stalling the last stage means nothing above it can move: a pure hold.
  localparam bit    FULL_HOLD = (STALL_STAGE == LAST);
  localparam word_t BUBBLE    = {1'b0, SELC_W'(NOP_SELC), TYPE_W'(NOP_TYPE), 2'b00};

  word_t            stage_q [DEPTH];
  word_t            stage_d [DEPTH];
  word_t            in_word;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mr_q, mr_d;
  logic             mw_q, mw_d;
  logic             strobe_en;

  // Next-state of every stage, bubble counter and strobes (FLUSH > STALL > advance).
  always_comb begin
    in_word   = bus.VALID_IN ? {1'b1, bus.SelC_in, bus.Type_in, bus.MR_IN, bus.MW_IN} : BUBBLE;
    stage_d   = stage_q;
    cnt_d     = cnt_q;
    strobe_en = 1'b0;
    if (bus.FLUSH) begin
      for (int i = 0; i < DEPTH; i++) stage_d[i] = BUBBLE;
    end else if (bus.STALL) begin
      if (!FULL_HOLD) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i == STALL_STAGE + 1)     stage_d[i] = BUBBLE;
          else if (i > STALL_STAGE + 1) stage_d[i] = stage_q[(i > 0) ? i - 1 : 0];
        end
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        strobe_en = 1'b1;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++)
        stage_d[i] = (i == 0) ? in_word : stage_q[(i > 0) ? i - 1 : 0];
      strobe_en = 1'b1;
    end
    // Strobes fire only on the edge a word enters the last stage.
    mr_d = strobe_en & stage_d[LAST].v & stage_d[LAST].mr;
    mw_d = strobe_en & stage_d[LAST].v & stage_d[LAST].mw;
  end

  // State registers, synchronous reset on the falling edge.
  always_ff @(negedge CK3) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= BUBBLE;
      cnt_q <= '0;
      mr_q  <= 1'b0;
      mw_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
    end
  end

  assign bus.SelC_out   = stage_q[LAST].selc;
  assign bus.Type_out   = stage_q[LAST].typ;
  assign bus.VALID_OUT  = stage_q[LAST].v;
  assign bus.MR_OUT     = mr_q;
  assign bus.MW_OUT     = mw_q;
  assign bus.BUBBLE_CNT = cnt_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_valid
    assign bus.STAGE_VALID[g] = stage_q[g].v;
  end

endmodule

// File: tb/tb_uc_pipe.sv
// Bench for uc_pipe: four instances (default, last-stage stall, 2-bit counter,
// single stage) share one stimulus stream. Every cycle each instance is checked
// against a queue-style reference model; directed steps add constant checks.
module tb_uc_pipe;

  logic CK3 = 1'b1;
  logic RST;
  always #5 CK3 = ~CK3;

  logic [5:0] d_sel;
  logic [6:0] d_typ;
  logic       d_mr, d_mw, d_valid, d_stall, d_flush;

  uc_pipe_if #(.DEPTH(3))            if_a ();
  uc_pipe_if #(.DEPTH(3))            if_b ();
  uc_pipe_if #(.DEPTH(3), .CNT_W(2)) if_c ();
  uc_pipe_if #(.DEPTH(1))            if_d ();

  assign if_a.SelC_in = d_sel;  assign if_a.Type_in = d_typ;  assign if_a.MR_IN = d_mr;
  assign if_a.MW_IN = d_mw;     assign if_a.VALID_IN = d_valid; assign if_a.STALL = d_stall;
  assign if_a.FLUSH = d_flush;
  assign if_b.SelC_in = d_sel;  assign if_b.Type_in = d_typ;  assign if_b.MR_IN = d_mr;
  assign if_b.MW_IN = d_mw;     assign if_b.VALID_IN = d_valid; assign if_b.STALL = d_stall;
  assign if_b.FLUSH = d_flush;
  assign if_c.SelC_in = d_sel;  assign if_c.Type_in = d_typ;  assign if_c.MR_IN = d_mr;
  assign if_c.MW_IN = d_mw;     assign if_c.VALID_IN = d_valid; assign if_c.STALL = d_stall;
  assign if_c.FLUSH = d_flush;
  assign if_d.SelC_in = d_sel;  assign if_d.Type_in = d_typ;  assign if_d.MR_IN = d_mr;
  assign if_d.MW_IN = d_mw;     assign if_d.VALID_IN = d_valid; assign if_d.STALL = d_stall;
  assign if_d.FLUSH = d_flush;

  uc_pipe #(.DEPTH(3), .STALL_STAGE(0))            dut_a (.CK3(CK3), .RST(RST), .bus(if_a));
  uc_pipe #(.DEPTH(3), .STALL_STAGE(2))            dut_b (.CK3(CK3), .RST(RST), .bus(if_b));
  uc_pipe #(.DEPTH(3), .STALL_STAGE(0), .CNT_W(2)) dut_c (.CK3(CK3), .RST(RST), .bus(if_c));
  uc_pipe #(.DEPTH(1), .STALL_STAGE(0))            dut_d (.CK3(CK3), .RST(RST), .bus(if_d));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: each instance is a list of words; index 0 is the entry.
  typedef struct {
    bit       v;
    bit [5:0] sel;
    bit [6:0] typ;
    bit       mr;
    bit       mw;
  } mword_t;

  localparam mword_t MBUB = '{v: 1'b0, sel: 6'd35, typ: 7'd0, mr: 1'b0, mw: 1'b0};
  int     m_depth [4] = '{3, 3, 3, 1};
  int     m_ss    [4] = '{0, 2, 0, 0};
  int     m_cmax  [4] = '{65535, 65535, 3, 65535};
  string  m_name  [4] = '{"A", "B", "C", "D"};
  mword_t mp      [4][3];
  int     m_cnt   [4];
  bit     m_mr    [4];
  bit     m_mw    [4];

  task automatic model_edge(input int n);
    bit     moved;
    mword_t last;
    moved = 1'b0;
    if (RST) begin
      for (int i = 0; i < 3; i++) mp[n][i] = MBUB;
      m_cnt[n] = 0;
    end else if (d_flush) begin
      for (int i = 0; i < 3; i++) mp[n][i] = MBUB;
    end else if (d_stall) begin
      if (m_ss[n] < m_depth[n] - 1) begin
        for (int i = m_depth[n] - 1; i > m_ss[n] + 1; i--) mp[n][i] = mp[n][i-1];
        mp[n][m_ss[n] + 1] = MBUB;
        if (m_cnt[n] < m_cmax[n]) m_cnt[n]++;
        moved = 1'b1;
      end
    end else begin
      for (int i = m_depth[n] - 1; i > 0; i--) mp[n][i] = mp[n][i-1];
      mp[n][0] = d_valid ? '{v: 1'b1, sel: d_sel, typ: d_typ, mr: d_mr, mw: d_mw} : MBUB;
      moved = 1'b1;
    end
    last    = mp[n][m_depth[n] - 1];
    m_mr[n] = moved & last.v & last.mr;
    m_mw[n] = moved & last.v & last.mw;
  endtask

  task automatic check_inst(input int n, input logic [5:0] sel, input logic [6:0] typ,
                            input logic mr, input logic mw, input logic v,
                            input logic [2:0] sv, input logic [15:0] cnt);
    logic [2:0] esv;
    mword_t     last;
    esv  = '0;
    for (int i = 0; i < m_depth[n]; i++) esv[i] = mp[n][i].v;
    last = mp[n][m_depth[n] - 1];
    chk({m_name[n], ".sel"}, 32'(sel), 32'(last.sel));
    chk({m_name[n], ".type"}, 32'(typ), 32'(last.typ));
    chk({m_name[n], ".valid"}, 32'(v), 32'(last.v));
    chk({m_name[n], ".mr"}, 32'(mr), 32'(m_mr[n]));
    chk({m_name[n], ".mw"}, 32'(mw), 32'(m_mw[n]));
    chk({m_name[n], ".stage_valid"}, 32'(sv), 32'(esv));
    chk({m_name[n], ".bubble_cnt"}, 32'(cnt), 32'(m_cnt[n]));
  endtask

  // One falling edge: advance the model, then compare all instances 2 time units later.
  task automatic tick();
    @(negedge CK3);
    for (int n = 0; n < 4; n++) model_edge(n);
    #2;
    check_inst(0, if_a.SelC_out, if_a.Type_out, if_a.MR_OUT, if_a.MW_OUT, if_a.VALID_OUT,
               if_a.STAGE_VALID, if_a.BUBBLE_CNT);
    check_inst(1, if_b.SelC_out, if_b.Type_out, if_b.MR_OUT, if_b.MW_OUT, if_b.VALID_OUT,
               if_b.STAGE_VALID, if_b.BUBBLE_CNT);
    check_inst(2, if_c.SelC_out, if_c.Type_out, if_c.MR_OUT, if_c.MW_OUT, if_c.VALID_OUT,
               if_c.STAGE_VALID, {14'd0, if_c.BUBBLE_CNT});
    check_inst(3, if_d.SelC_out, if_d.Type_out, if_d.MR_OUT, if_d.MW_OUT, if_d.VALID_OUT,
               {2'd0, if_d.STAGE_VALID}, if_d.BUBBLE_CNT);
  endtask

  task automatic drive(input logic valid, input logic [5:0] sel, input logic [6:0] typ,
                       input logic mr, input logic mw);
    d_valid = valid; d_sel = sel; d_typ = typ; d_mr = mr; d_mw = mw;
  endtask

  initial begin
    RST = 1'b1; d_stall = 1'b0; d_flush = 1'b0;
    drive(1'b0, 6'd0, 7'd0, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 3; i++) mp[n][i] = MBUB;
      m_cnt[n] = 0; m_mr[n] = 1'b0; m_mw[n] = 1'b0;
    end

    // Reset state
    tick();
    chk("rst.sel", 32'(if_a.SelC_out), 32'd35);
    chk("rst.type", 32'(if_a.Type_out), 32'd0);
    chk("rst.valid", 32'(if_a.VALID_OUT), 32'd0);
    chk("rst.strobes", 32'({if_a.MR_OUT, if_a.MW_OUT}), 32'd0);
    chk("rst.stage_valid", 32'(if_a.STAGE_VALID), 32'd0);
    chk("rst.cnt", 32'(if_a.BUBBLE_CNT), 32'd0);
    RST = 1'b0;

    // Streaming: three words on consecutive edges
    drive(1'b1, 6'd1, 7'd10, 1'b0, 1'b0); tick();
    chk("stream.d1", 32'(if_d.SelC_out), 32'd1);
    drive(1'b1, 6'd2, 7'd11, 1'b0, 1'b0); tick();
    drive(1'b1, 6'd3, 7'd12, 1'b0, 1'b0); tick();
    chk("stream.w1", 32'({if_a.SelC_out, if_a.Type_out, if_a.VALID_OUT}), 32'({6'd1, 7'd10, 1'b1}));
    drive(1'b0, 6'd0, 7'd0, 1'b0, 1'b0); tick();
    chk("stream.w2", 32'({if_a.SelC_out, if_a.Type_out, if_a.VALID_OUT}), 32'({6'd2, 7'd11, 1'b1}));
    tick();
    chk("stream.w3", 32'({if_a.SelC_out, if_a.Type_out, if_a.VALID_OUT}), 32'({6'd3, 7'd12, 1'b1}));
    tick();
    chk("stream.end", 32'(if_a.VALID_OUT), 32'd0);

    // Stall bubble insertion above stage 0
    drive(1'b1, 6'd5, 7'd0, 1'b0, 1'b0); tick();
    drive(1'b0, 6'd0, 7'd0, 1'b0, 1'b0); d_stall = 1'b1;
    tick(); tick();
    chk("stall.cnt", 32'(if_a.BUBBLE_CNT), 32'd2);
    chk("stall.hold_b_cnt", 32'(if_b.BUBBLE_CNT), 32'd0);
    d_stall = 1'b0; tick();
    chk("stall.bubble", 32'({if_a.SelC_out, if_a.VALID_OUT}), 32'({6'd35, 1'b0}));
    tick();
    chk("stall.wordA", 32'({if_a.SelC_out, if_a.VALID_OUT}), 32'({6'd5, 1'b1}));
    tick();
    chk("stall.once", 32'({if_a.SelC_out, if_a.VALID_OUT}), 32'({6'd35, 1'b0}));

    // One-shot read while the last stage is held
    RST = 1'b1; tick(); RST = 1'b0;
    drive(1'b1, 6'd7, 7'd3, 1'b1, 1'b0); tick();
    drive(1'b0, 6'd0, 7'd0, 1'b0, 1'b0); tick(); tick();
    chk("oneshot.first", 32'({if_b.SelC_out, if_b.MR_OUT, if_b.MW_OUT}), 32'({6'd7, 1'b1, 1'b0}));
    d_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("oneshot.held", 32'({if_b.SelC_out, if_b.VALID_OUT, if_b.MR_OUT, if_b.MW_OUT}),
          32'({6'd7, 1'b1, 1'b0, 1'b0}));
    end
    d_stall = 1'b0;

    // Flush wins over stall with three valid words in flight
    drive(1'b1, 6'd20, 7'd1, 1'b1, 1'b1); tick();
    drive(1'b1, 6'd21, 7'd2, 1'b1, 1'b1); tick();
    drive(1'b1, 6'd22, 7'd4, 1'b1, 1'b1); tick();
    chk("flush.pre_sv", 32'(if_a.STAGE_VALID), 32'd7);
    d_stall = 1'b1; d_flush = 1'b1; tick();
    chk("flush.sv", 32'(if_a.STAGE_VALID), 32'd0);
    chk("flush.sel", 32'(if_a.SelC_out), 32'd35);
    chk("flush.cnt", 32'(if_a.BUBBLE_CNT), 32'd3);
    chk("flush.strobes", 32'({if_a.MR_OUT, if_a.MW_OUT}), 32'd0);
    d_flush = 1'b0;

    // Counter saturation on the 2-bit instance, then reset mid-stall
    drive(1'b0, 6'd0, 7'd0, 1'b0, 1'b0);
    RST = 1'b1; tick(); RST = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("sat.cnt", 32'(if_c.BUBBLE_CNT), (i < 3) ? 32'(i) : 32'd3);
    end
    chk("sat.wide_cnt", 32'(if_a.BUBBLE_CNT), 32'd5);
    RST = 1'b1; tick(); RST = 1'b0;
    chk("sat.rst", 32'(if_c.BUBBLE_CNT), 32'd0);
    d_stall = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      RST     = ($urandom_range(0, 99) == 0);
      d_flush = ($urandom_range(0, 15) == 0);
      d_stall = ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 3) != 0, 6'($urandom), 7'($urandom),
            1'($urandom), 1'($urandom));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uc_pipe.md
Name: uc_pipe

Overview:
- Parametrised control-word pipeline for the control unit.
- Carries {SelC, Type, MR, MW} through DEPTH registered stages.
- Supports stall with bubble insertion at a configurable stage, a full flush, and one-shot memory strobes while held.
- Sits between instruction decode and the datapath/memory interface, and replaces the fixed single-stage control register.

Parameters:
- DEPTH, 3: number of pipeline stages (>=1).
- SELC_W, 6: SelC width.
- TYPE_W, 7: Type width.
- NOP_SELC, 35: SelC value of a bubble.
- NOP_TYPE, 0: Type value of a bubble.
- STALL_STAGE, 0: highest stage index frozen by STALL (0..DEPTH-1).
- CNT_W, 16: width of the bubble counter.

Ports:
- CK3  in  1  clock; all state updates on the falling edge.
- RST  in  1  synchronous active-high reset, sampled on the falling edge of CK3.
- SelC_in  in  SELC_W  incoming register-select word.
- Type_in  in  TYPE_W  incoming operation type.
- MR_IN  in  1  memory-read request of the incoming word.
- MW_IN  in  1  memory-write request of the incoming word.
- VALID_IN  in  1  incoming word valid; 0 loads a bubble.
- STALL  in  1  freeze stages 0..STALL_STAGE; upstream holds its word.
- FLUSH  in  1  kill all in-flight words.
- SelC_out  out  SELC_W  last-stage SelC.
- Type_out  out  TYPE_W  last-stage Type.
- MR_OUT  out  1  one-shot read strobe.
- MW_OUT  out  1  one-shot write strobe.
- VALID_OUT  out  1  last stage holds a valid word.
- STAGE_VALID  out  DEPTH  valid bit per stage; bit i = stage i.
- BUBBLE_CNT  out  CNT_W  count of stall-inserted bubbles.

Behaviour:
- Stage i holds {v, selc, type, mr, mw}.
- Bubble = {0, NOP_SELC, NOP_TYPE, 0, 0}.
- Priority on each falling edge: RST > FLUSH > STALL > normal advance.
- RST: every stage becomes a bubble; BUBBLE_CNT = 0; MR_OUT = MW_OUT = 0; SelC_out = NOP_SELC; Type_out = NOP_TYPE; VALID_OUT = 0; STAGE_VALID = 0.
- Normal advance: s0 <= input word if VALID_IN=1, else bubble (SelC/Type forced to NOP values, MR/MW forced 0). s[i] <= s[i-1].
- Latency: a word accepted on edge k is visible on the outputs after edge k+DEPTH-1 (DEPTH edges total, counting edge k).
- STALL=1, FLUSH=0:
  - Stages 0..STALL_STAGE hold; input is not accepted.
  - If STALL_STAGE < DEPTH-1: s[STALL_STAGE+1] <= bubble, stages above advance, and BUBBLE_CNT increments.
  - If STALL_STAGE = DEPTH-1: the whole pipe holds, no bubble is inserted, and the counter does not change.
- FLUSH=1:
  - Every stage becomes a bubble; input is discarded; STALL is ignored.
  - BUBBLE_CNT does not change.
  - MR_OUT = MW_OUT = 0 on that edge.
- BUBBLE_CNT:
  - Saturates at all-ones.
  - Only stall insertions count; VALID_IN=0 bubbles, flush and reset do not.
- Memory strobes:
  - MR_OUT/MW_OUT are registered.
  - On an edge where a new word enters the last stage, MR_OUT <= new.v & new.mr and MW_OUT <= new.v & new.mw.
  - On an edge where the last stage holds, both strobes go to 0.
  - Result: each valid word pulses its strobes for exactly one cycle, however long it is held.
  - SelC_out, Type_out and VALID_OUT stay stable while the word is held.
- DEPTH=1: s0 is the last stage. STALL with STALL_STAGE=0 is a full hold.
- A stall released mid-sequence resumes with no word lost or duplicated. The held word advances on the first edge with STALL=0.
- Reset asserted mid-stall or mid-flush: the reset state on that edge, unconditionally.

Test Plan:
- Reset (defaults): RST=1 for one edge -> SelC_out=35, Type_out=0, VALID_OUT=0, MR_OUT=MW_OUT=0, STAGE_VALID=3'b000, BUBBLE_CNT=0.
- Streaming (DEPTH=3): inputs SelC 1,2,3 / Type 10,11,12 valid on consecutive edges k,k+1,k+2 -> visible on outputs after edges k+2, k+3, k+4 respectively, in order; VALID_OUT=1 for three cycles.
- Stall bubble (DEPTH=3, STALL_STAGE=0): word A (SelC 5) in s0, STALL=1 for 2 edges then 0 -> outputs show 2 bubbles (SelC 35) before A; A appears once; BUBBLE_CNT=2.
- One-shot read (STALL_STAGE=2): word SelC 7, MR_IN=1 reaches the last stage, then STALL=1 for 3 edges -> SelC_out=7 for 4 cycles; MR_OUT high only in the first; MW_OUT stays 0.
- Flush over stall: STALL=1 and FLUSH=1 on the same edge with 3 valid words in flight -> STAGE_VALID=000, SelC_out=35, BUBBLE_CNT unchanged, no strobes.
- Saturation (CNT_W=2, STALL_STAGE=0): 5 consecutive stall edges -> BUBBLE_CNT=3 and stays 3; RST -> 0.
